// File: rtl/shared_ram_arbiter.sv
// Round-robin arbiter serialising per-core indirect loads/stores onto one single-port data RAM.
// Each access takes IDLE -> ACCESS -> RESP, with a one-cycle ack pulse to the served core in RESP.
module shared_ram_arbiter #(
  parameter int unsigned N_CORES = 8,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_CORES-1:0]        req,
  input  logic [N_CORES-1:0]        we,
  input  logic [N_CORES*ADDR_W-1:0] addr,
  input  logic [N_CORES*DATA_W-1:0] wdata,
  output logic [N_CORES-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic                      ram_we,
  output logic [DATA_W-1:0]         ram_wdata,
  input  logic [DATA_W-1:0]         ram_rdata,
  output logic [2:0]                grant_id,
  output logic                      busy
);

  localparam int unsigned PtrW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic [PtrW-1:0]     gnt_q, gnt_d;
  logic                load_q, load_d;
  logic [N_CORES-1:0]  ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic                ram_we_q, ram_we_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                busy_q, busy_d;

  logic                win_found;
  logic [PtrW-1:0]     win_idx;
  logic [PtrW-1:0]     scan_idx;

  // Scan from the farthest offset back to ptr so the nearest requester is written last and wins.
  // N_CORES is a power of two, so PtrW-bit addition wraps modulo N_CORES for free.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = int'(N_CORES) - 1; k >= 0; k--) begin
      scan_idx = ptr_q + PtrW'(k);
      if (req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    load_d      = load_q;
    ack_d       = '0;
    rdata_d     = rdata_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = ram_we_q;
    ram_wdata_d = ram_wdata_q;
    busy_d      = busy_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          ram_addr_d  = addr[32'(win_idx) * ADDR_W +: ADDR_W];
          ram_wdata_d = wdata[32'(win_idx) * DATA_W +: DATA_W];
          ram_we_d    = we[win_idx];
          load_d      = ~we[win_idx];
          gnt_d       = win_idx;
          ptr_d       = win_idx + PtrW'(1);
          busy_d      = 1'b1;
          state_d     = StAccess;
        end
      end
      StAccess: begin
        ram_we_d       = 1'b0;
        ack_d[gnt_q]   = 1'b1;
        state_d        = StResp;
      end
      StResp: begin
        if (load_q) begin
          rdata_d = ram_rdata;
        end
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      gnt_q       <= '0;
      load_q      <= 1'b0;
      ack_q       <= '0;
      rdata_q     <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      load_q      <= load_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      busy_q      <= busy_d;
    end
  end

  // The synchronous RAM only presents load data in the RESP cycle itself, so pass it through
  // there; rdata_q keeps it afterwards.
  assign rdata     = ((state_q == StResp) && load_q) ? ram_rdata : rdata_q;
  assign ack       = ack_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;
  assign grant_id  = 3'(gnt_q);
  assign busy      = busy_q;

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Randomized bench for shared_ram_arbiter: a transaction-level schedule model predicts every
// cycle's ack, busy, RAM port activity and load data; directed scenarios cover the edge cases.
module tb_shared_ram_arbiter;
  localparam int N  = 8;
  localparam int AW = 8;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req, we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rdata, ram_wdata, ram_rdata;
  logic [AW-1:0]   ram_addr;
  logic            ram_we;
  logic [2:0]      grant_id;
  logic            busy;

  shared_ram_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .ack       (ack),
    .rdata     (rdata),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // RAM instance the arbiter drives; content starts as addr ^ 0x3B (so RAM[0x10] = 0x2B).
  logic [7:0] mem [256];
  logic       mem_init_done = 1'b0;
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h3B;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Core-side request state
  logic [N-1:0] pending;
  logic [N-1:0] persist;
  logic         rand_en;
  logic         p_we    [N];
  logic [7:0]   p_addr  [N];
  logic [7:0]   p_wdata [N];
  int           ack_cnt [N];

  // Reference model: one outstanding scheduled access plus the priority pointer and memory image
  logic [7:0] ref_mem [256];
  int         cyc, m_ptr;
  logic       s_valid, s_we;
  int         s_cyc, s_g;
  logic [7:0] s_addr, s_wdata, s_data;

  task automatic drive_inputs();
    req = pending;
    for (int i = 0; i < N; i++) begin
      we[i]             = p_we[i];
      addr[i*AW +: AW]  = p_addr[i];
      wdata[i*DW +: DW] = p_wdata[i];
    end
  endtask

  task automatic set_req(input int i, input logic w, input logic [7:0] a, input logic [7:0] d);
    pending[i] = 1'b1;
    p_we[i]    = w;
    p_addr[i]  = a;
    p_wdata[i] = d;
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      logic [N-1:0] exp_ack;
      logic         in_acc, in_resp;
      int           g;
      in_acc  = s_valid && (cyc == s_cyc + 1);
      in_resp = s_valid && (cyc == s_cyc + 2);
      exp_ack = '0;
      if (in_resp) exp_ack[s_g] = 1'b1;
      check_eq("ack", 32'(ack), 32'(exp_ack));
      check_eq("busy", 32'(busy), 32'(in_acc || in_resp));
      check_eq("ram_we", 32'(ram_we), 32'(in_acc && s_we));
      if (in_acc) begin
        check_eq("ram_addr", 32'(ram_addr), 32'(s_addr));
        if (s_we) check_eq("ram_wdata", 32'(ram_wdata), 32'(s_wdata));
      end
      if (in_acc || in_resp) check_eq("grant_id", 32'(grant_id), 32'(s_g));
      if (in_resp && !s_we) check_eq("rdata", 32'(rdata), 32'(s_data));

      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          pending[i] = 1'b0;
          ack_cnt[i]++;
        end else if (!pending[i]) begin
          if (persist[i]) begin
            set_req(i, 1'b0, 8'(i), 8'h00);
          end else if (rand_en && $urandom_range(0, 3) == 0) begin
            set_req(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)), 8'($urandom));
          end
        end
      end
      drive_inputs();

      if ((!s_valid || cyc >= s_cyc + 3) && pending != '0) begin
        g = -1;
        for (int j = 0; j < N; j++) begin
          if (g < 0 && pending[(m_ptr + j) % N]) g = (m_ptr + j) % N;
        end
        s_valid = 1'b1;
        s_cyc   = cyc;
        s_g     = g;
        s_we    = p_we[g];
        s_addr  = p_addr[g];
        s_wdata = p_wdata[g];
        if (s_we) ref_mem[s_addr] = s_wdata;
        else s_data = ref_mem[s_addr];
        m_ptr = (g + 1) % N;
      end

      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic reset_dut();
    reset   = 1'b0;
    pending = '0;
    persist = '0;
    rand_en = 1'b0;
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ack", 32'(ack), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_ram_we", 32'(ram_we), 32'h0);
    check_eq("rst_ram_addr", 32'(ram_addr), 32'h0);
    check_eq("rst_ram_wdata", 32'(ram_wdata), 32'h0);
    check_eq("rst_grant_id", 32'(grant_id), 32'h0);
    check_eq("rst_rdata", 32'(rdata), 32'h0);
    reset   = 1'b1;
    s_valid = 1'b0;
    m_ptr   = 0;
    cyc     = 0;
    for (int i = 0; i < N; i++) ack_cnt[i] = 0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      p_we[i] = 1'b0;
      p_addr[i] = '0;
      p_wdata[i] = '0;
      ack_cnt[i] = 0;
    end
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h3B;
    pending = '0;
    persist = '0;
    rand_en = 1'b0;
    s_valid = 1'b0;
    s_cyc = 0; s_g = 0; s_we = 1'b0; s_addr = '0; s_wdata = '0; s_data = '0;
    m_ptr = 0;
    cyc = 0;
    reset = 1'b0;
    drive_inputs();
    @(posedge clk);
    #1;
    mem_init_done = 1'b1;

    // Single load from core 3
    reset_dut();
    set_req(3, 1'b0, 8'h10, 8'h00);
    run_cycles(6);
    check_eq("single_load_once", 32'(ack_cnt[3]), 32'd1);

    // Store from core 5, then load of the same address from core 2
    reset_dut();
    set_req(5, 1'b1, 8'hC4, 8'h7E);
    run_cycles(4);
    set_req(2, 1'b0, 8'hC4, 8'h00);
    run_cycles(5);
    check_eq("store_commit", 32'(mem[8'hC4]), 32'h7E);

    // Full contention: all eight cores load at once
    reset_dut();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'(8'h40 + i), 8'h00);
    run_cycles(27);
    check_eq("contention_drained", 32'(pending), 32'h0);
    for (int i = 0; i < N; i++) check_eq("contention_once", 32'(ack_cnt[i]), 32'd1);

    // Round-robin wrap: move ptr to 7 via core 6, then cores 0 and 7 request continuously
    reset_dut();
    set_req(6, 1'b0, 8'h06, 8'h00);
    run_cycles(3);
    persist = 8'h81;
    run_cycles(24);
    check_eq("wrap_core7_served", 32'(ack_cnt[7] >= 4), 32'd1);
    check_eq("wrap_core0_served", 32'(ack_cnt[0] >= 3), 32'd1);
    persist = '0;

    // Reset in the ACCESS cycle of a store from core 1
    reset_dut();
    set_req(1, 1'b1, 8'h20, 8'h55);
    run_cycles(1);
    check_eq("rst_acc_we", 32'(ram_we), 32'h1);
    reset   = 1'b0;
    pending = '0;
    drive_inputs();
    @(posedge clk);
    #1;
    check_eq("rst_acc_commit", 32'(mem[8'h20]), 32'h55);
    check_eq("rst_acc_ack", 32'(ack), 32'h0);
    check_eq("rst_acc_busy", 32'(busy), 32'h0);
    check_eq("rst_acc_ram_addr", 32'(ram_addr), 32'h0);
    check_eq("rst_acc_ram_we", 32'(ram_we), 32'h0);
    check_eq("rst_acc_grant", 32'(grant_id), 32'h0);
    @(posedge clk);
    #1;
    check_eq("rst_acc_no_ack", 32'(ack), 32'h0);
    reset   = 1'b1;
    s_valid = 1'b0;
    m_ptr   = 0;
    cyc     = 0;
    for (int i = 0; i < N; i++) ack_cnt[i] = 0;
    set_req(7, 1'b0, 8'h20, 8'h00);
    set_req(0, 1'b0, 8'h21, 8'h00);
    run_cycles(8);
    check_eq("rst_ptr_zero_core0", 32'(ack_cnt[0]), 32'd1);
    check_eq("rst_ptr_zero_core7", 32'(ack_cnt[7]), 32'd1);

    // Idle: no requests for 20 cycles
    reset_dut();
    run_cycles(20);

    // Randomized traffic
    reset_dut();
    rand_en = 1'b1;
    run_cycles(1500);
    rand_en = 1'b0;
    run_cycles(30);
    check_eq("random_drained", 32'(pending), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
